fp_issue_ctrl: RTL
==================

Name: fp_issue_ctrl

Overview:
- In-order issue and completion controller between the FP decode stage and the single-precision FPU datapath.
- Accepts one decoded FP op per cycle and resolves dynamic rounding mode against frm.
- Routes each op to either the fixed-latency pipelined path or the iterative div/sqrt unit, and returns completions in program order.
- Accumulates exception flags and owns the fflags/frm/fcsr CSRs.

Parameters:
PIPE_LAT, 4, latency in cycles from exe_valid to result/flags for the pipelined path (range 1..15)
TAG_W, 5, width of the request tag returned with completion

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  decoded FP op offered
req_ready  out  1  op accepted when req_valid&req_ready
req_opcode  in  7  opcode_fp or one of opcode_fmadd/fmsub/fnmsub/fnmadd
req_funct5  in  5  funct_* code (valid when opcode_fp)
req_rm  in  3  instruction rm field
req_tag  in  TAG_W  opaque tag
exe_valid  out  1  one-cycle issue pulse to pipelined path
div_start  out  1  one-cycle start pulse to iterative unit
exe_rm  out  3  resolved static rounding mode, valid with exe_valid/div_start
exe_tag  out  TAG_W  tag of issued op
pipe_flags  in  5  NV,DZ,OF,UF,NX of the pipelined op, sampled PIPE_LAT cycles after its exe_valid
div_done  in  1  iterative unit finished (single-cycle pulse)
div_flags  in  5  flags valid with div_done
cmp_valid  out  1  completion pulse, in program order
cmp_tag  out  TAG_W  tag of completing op
cmp_exc  out  1  illegal-instruction completion (no result)
csr_valid  in  1  CSR access request
csr_ready  out  1  high only when no op is in flight
csr_addr  in  12  csr_fflags/csr_frm/csr_fcsr
csr_wen  in  1  write enable
csr_wdata  in  8  write data (low bits used)
csr_rvalid  out  1  registered response, one cycle after accept
csr_rdata  out  8  old CSR value (swap semantics), zero-extended
csr_err  out  1  with csr_rvalid: unknown address, no state change
frm  out  3  current frm

Behaviour:
- Reset: all outputs 0, except req_ready=1 and csr_ready=1. fflags=0, frm=0, state RUN, pipe tracker empty.
- Op classes:
  - ITER: opcode_fp with funct_fdiv or funct_fsqrt.
  - ILL: unknown funct5; or an rm-using op (fadd, fsub, fmul, fdiv, fsqrt, fconv_*, fmadd family) with rm in {5,6}, or rm=7 while frm in {5,6,7}.
  - PIPE: everything else.
  - rm for non-rm ops (fsgnj, fminmax, fcomp, fclass/fmv, fmv_i2f) is passed through unchecked.
- Rounding: exe_rm = (req_rm==7) ? frm : req_rm.
- Pipe tracker: a PIPE_LAT-deep shift register of {valid,tag}.
  - A PIPE op issues exe_valid in its accept cycle; throughput is 1 per cycle.
  - The tracker output asserts cmp_valid/cmp_tag, and fflags |= pipe_flags in the same cycle.
- FSM:
  - RUN: req_ready=1 for PIPE ops. For an ITER/ILL op, req_ready=0 until the tracker is empty.
    - ITER accepted -> div_start pulse, go to ITER.
    - ILL accepted -> go to ILLC.
  - ITER: req_ready=0. On div_done: cmp_valid, cmp_tag = held tag, fflags |= div_flags, go to RUN.
  - ILLC: one cycle with cmp_valid=1, cmp_exc=1, fflags unchanged, then RUN.
- Ordering: a completion collision is impossible by construction; the bench asserts at most one cmp source per cycle.
- CSR access:
  - Accepted only when csr_ready, i.e. state RUN, tracker empty and no req accepted this cycle. A concurrent req wins; the CSR waits.
  - fcsr = {frm,fflags}. Writes of fflags/frm/fcsr update the corresponding fields.
  - csr_rdata is the value before the write.
  - The first op accepted after a frm write sees the new frm.
- div_done outside ITER is ignored.
- Reset mid-operation: in-flight ops are dropped with no completion; any later div_done is ignored.

Decomposition:
- Add to the shared FP constants package:
  - rm_rne..rm_rmm and rm_dyn=3'b111
  - issue-controller state enum {RUN, ITER, ILLC}
  - fflags bit positions
- Natural sub-module fp_csr: fflags/frm storage, flag OR-accumulate, CSR decode and swap read, csr_err.

Test Plan:
- Reset -> req_ready=1, csr_ready=1, frm=0, fflags=0, no cmp_valid for 10 cycles.
- PIPE_LAT=4, fadd tags 1,2,3 accepted cycles 0,1,2, rm=0; pipe_flags=5'b00001 at cycle 5 -> cmp_valid cycles 4,5,6 with tags 1,2,3; fflags=0x01.
- fadd tag 4 at cycle 0, fdiv tag 5 offered cycle 1 -> fdiv held until tracker empty; div_start at cycle 4; div_done with flags 5'b01000 at cycle 14 -> cmp tag 4 at cycle 4, cmp tag 5 at cycle 14; fflags |= 0x08.
- CSR write fcsr=0xA5 from reset -> rdata 0x00; frm=5, fflags=0x05. Then fmul rm=7 -> cmp_exc=1, no exe_valid, fflags stays 0x05.
- frm=1 (via csr_frm write 0x1, rdata 0x0), fsub rm=7 -> exe_rm=1. fsgnj with rm=6 -> PIPE, no exception.
- Reset asserted during ITER, then div_done -> no cmp_valid, state RUN, fflags=0.

Source files
------------

// File: rtl/fp_issue_ctrl_pkg.sv
// Shared FP constants for the issue controller: instruction encodings,
// rounding modes, CSR addresses, fflags bit positions, the controller
// state enum, and the op classifier used at the issue point.
package fp_issue_ctrl_pkg;

    // Major opcodes
    localparam logic [6:0] opcode_fp     = 7'b1010011;
    localparam logic [6:0] opcode_fmadd  = 7'b1000011;
    localparam logic [6:0] opcode_fmsub  = 7'b1000111;
    localparam logic [6:0] opcode_fnmsub = 7'b1001011;
    localparam logic [6:0] opcode_fnmadd = 7'b1001111;

    // funct5 codes under opcode_fp
    localparam logic [4:0] funct_fadd      = 5'b00000;
    localparam logic [4:0] funct_fsub      = 5'b00001;
    localparam logic [4:0] funct_fmul      = 5'b00010;
    localparam logic [4:0] funct_fdiv      = 5'b00011;
    localparam logic [4:0] funct_fsgnj     = 5'b00100;
    localparam logic [4:0] funct_fminmax   = 5'b00101;
    localparam logic [4:0] funct_fsqrt     = 5'b01011;
    localparam logic [4:0] funct_fcomp     = 5'b10100;
    localparam logic [4:0] funct_fconv_f2i = 5'b11000;
    localparam logic [4:0] funct_fconv_i2f = 5'b11010;
    localparam logic [4:0] funct_fclass    = 5'b11100;
    localparam logic [4:0] funct_fmv_i2f   = 5'b11110;

    // Rounding modes
    localparam logic [2:0] rm_rne = 3'b000;
    localparam logic [2:0] rm_rtz = 3'b001;
    localparam logic [2:0] rm_rdn = 3'b010;
    localparam logic [2:0] rm_rup = 3'b011;
    localparam logic [2:0] rm_rmm = 3'b100;
    localparam logic [2:0] rm_dyn = 3'b111;

    // CSR addresses
    localparam logic [11:0] csr_fflags = 12'h001;
    localparam logic [11:0] csr_frm    = 12'h002;
    localparam logic [11:0] csr_fcsr   = 12'h003;

    // fflags bit positions
    localparam int fflag_nx = 0;
    localparam int fflag_uf = 1;
    localparam int fflag_of = 2;
    localparam int fflag_dz = 3;
    localparam int fflag_nv = 4;

    typedef enum logic [1:0] {RUN, ITER, ILLC} issue_state_e;
    typedef enum logic [1:0] {CLS_PIPE, CLS_ITER, CLS_ILL} op_class_e;

    // Classify a decoded op. A dynamic rm is judged against the current frm,
    // so an op becomes illegal if frm holds a reserved encoding at issue.
    function automatic op_class_e classify_op(input logic [6:0] opcode,
                                              input logic [4:0] funct5,
                                              input logic [2:0] rm,
                                              input logic [2:0] frm);
        logic known, uses_rm, is_iter, rm_bad;
        known   = 1'b0;
        uses_rm = 1'b0;
        is_iter = 1'b0;
        if (opcode == opcode_fmadd || opcode == opcode_fmsub ||
            opcode == opcode_fnmsub || opcode == opcode_fnmadd) begin
            known   = 1'b1;
            uses_rm = 1'b1;
        end else if (opcode == opcode_fp) begin
            case (funct5)
                funct_fadd, funct_fsub, funct_fmul,
                funct_fconv_f2i, funct_fconv_i2f: begin
                    known   = 1'b1;
                    uses_rm = 1'b1;
                end
                funct_fdiv, funct_fsqrt: begin
                    known   = 1'b1;
                    uses_rm = 1'b1;
                    is_iter = 1'b1;
                end
                funct_fsgnj, funct_fminmax, funct_fcomp,
                funct_fclass, funct_fmv_i2f: known = 1'b1;
                default: known = 1'b0;
            endcase
        end
        rm_bad = (rm == 3'd5) || (rm == 3'd6) || ((rm == rm_dyn) && (frm >= 3'd5));
        if (!known || (uses_rm && rm_bad)) return CLS_ILL;
        if (is_iter) return CLS_ITER;
        return CLS_PIPE;
    endfunction

endpackage

// File: rtl/fp_issue_ctrl_csr.sv
// FP CSR file: holds fflags and frm, OR-accumulates completion flags, and
// serves fflags/frm/fcsr accesses with swap semantics (old value returned,
// new value written). The response is registered one cycle after accept.
//   i_acc                   access accepted this cycle
//   i_addr/i_wen/i_wdata    access address, write enable, write data
//   i_flag_en/i_flag_set    completion flags to OR into fflags
//   o_frm/o_fflags          current CSR state
//   o_rvalid/o_rdata/o_err  registered response; o_err for unknown address
module fp_csr
    import fp_issue_ctrl_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_acc,
    input  logic [11:0] i_addr,
    input  logic        i_wen,
    input  logic [7:0]  i_wdata,
    input  logic        i_flag_en,
    input  logic [4:0]  i_flag_set,
    output logic [2:0]  o_frm,
    output logic [4:0]  o_fflags,
    output logic        o_rvalid,
    output logic [7:0]  o_rdata,
    output logic        o_err
);

    logic [4:0] r_fflags;
    logic [2:0] r_frm;
    logic       r_rvalid;
    logic [7:0] r_rdata;
    logic       r_err;

    logic       w_known;
    logic [7:0] w_old;
    logic       w_wr;

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_known = 1'b1;
        w_old   = 8'h00;
        case (i_addr)
            csr_fflags: w_old = {3'b000, r_fflags};
            csr_frm:    w_old = {5'b00000, r_frm};
            csr_fcsr:   w_old = {r_frm, r_fflags};
            default:    w_known = 1'b0;
        endcase
    end

    assign w_wr = i_acc && i_wen && w_known;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_fflags <= 5'b0;
            r_frm    <= 3'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= 8'h00;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= i_acc;
            r_rdata  <= (i_acc && w_known) ? w_old : 8'h00;
            r_err    <= i_acc && !w_known;
            // An access is only accepted with nothing in flight, so a write
            // and a flag accumulation never land in the same cycle.
            if (w_wr && (i_addr == csr_fflags)) r_fflags <= i_wdata[4:0];
            else if (w_wr && (i_addr == csr_fcsr)) r_fflags <= i_wdata[4:0];
            else if (i_flag_en) r_fflags <= r_fflags | i_flag_set;
            if (w_wr && (i_addr == csr_frm)) r_frm <= i_wdata[2:0];
            else if (w_wr && (i_addr == csr_fcsr)) r_frm <= i_wdata[7:5];
        end
    end

    assign o_frm    = r_frm;
    assign o_fflags = r_fflags;
    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_err    = r_err;

endmodule

// File: rtl/fp_issue_ctrl.sv
// In-order FP issue/completion controller. Classifies each decoded op,
// resolves dynamic rounding against frm, issues to the pipelined path or the
// iterative div/sqrt unit, and returns completions in program order.
//   req_*   decoded op handshake (valid/ready, opcode, funct5, rm, tag)
//   exe_*   issue pulse / div_start with resolved rm and tag
//   pipe_flags, div_done/div_flags   completion inputs from the datapath
//   cmp_*   in-order completion pulse, tag, illegal-instruction marker
//   csr_*   CSR access handshake and registered response; frm output
module fp_issue_ctrl
    import fp_issue_ctrl_pkg::*;
#(
    parameter int PIPE_LAT = 4,
    parameter int TAG_W    = 5
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [6:0]       i_req_opcode,
    input  logic [4:0]       i_req_funct5,
    input  logic [2:0]       i_req_rm,
    input  logic [TAG_W-1:0] i_req_tag,
    output logic             o_exe_valid,
    output logic             o_div_start,
    output logic [2:0]       o_exe_rm,
    output logic [TAG_W-1:0] o_exe_tag,
    input  logic [4:0]       i_pipe_flags,
    input  logic             i_div_done,
    input  logic [4:0]       i_div_flags,
    output logic             o_cmp_valid,
    output logic [TAG_W-1:0] o_cmp_tag,
    output logic             o_cmp_exc,
    input  logic             i_csr_valid,
    output logic             o_csr_ready,
    input  logic [11:0]      i_csr_addr,
    input  logic             i_csr_wen,
    input  logic [7:0]       i_csr_wdata,
    output logic             o_csr_rvalid,
    output logic [7:0]       o_csr_rdata,
    output logic             o_csr_err,
    output logic [2:0]       o_frm
);

    // Every tracker stage except the last; the last stage retires this cycle.
    localparam logic [PIPE_LAT-1:0] BUSY_MASK = {PIPE_LAT{1'b1}} >> 1;

    issue_state_e     r_state, w_state_nxt;
    logic [PIPE_LAT-1:0] r_pv;
    logic [TAG_W-1:0] r_pt [PIPE_LAT];
    logic [TAG_W-1:0] r_held_tag;

    op_class_e        w_class;
    logic [2:0]       w_frm;
    logic [4:0]       w_fflags;
    logic             w_req_ready, w_accept;
    logic             w_issue_pipe, w_issue_div;
    logic             w_cmp_fsm, w_cmp_exc, w_div_flag_en;
    logic             w_pipe_out, w_pipe_busy, w_pipe_empty;
    logic             w_csr_acc;

    assign w_pipe_out   = r_pv[PIPE_LAT-1];
    assign w_pipe_busy  = |(r_pv & BUSY_MASK);
    assign w_pipe_empty = (r_pv == '0);
    assign w_class      = classify_op(i_req_opcode, i_req_funct5, i_req_rm, w_frm);

    always_comb begin
        w_state_nxt   = r_state;
        w_req_ready   = 1'b0;
        w_issue_pipe  = 1'b0;
        w_issue_div   = 1'b0;
        w_cmp_fsm     = 1'b0;
        w_cmp_exc     = 1'b0;
        w_div_flag_en = 1'b0;
        case (r_state)
            RUN: begin
                // ITER/ILL wait for older pipelined ops so completions
                // stay in program order without a collision.
                w_req_ready = !i_req_valid || (w_class == CLS_PIPE) || !w_pipe_busy;
                if (i_req_valid && w_req_ready) begin
                    case (w_class)
                        CLS_PIPE: w_issue_pipe = 1'b1;
                        CLS_ITER: begin
                            w_issue_div = 1'b1;
                            w_state_nxt = ITER;
                        end
                        default:  w_state_nxt = ILLC;
                    endcase
                end
            end
            ITER: begin
                if (i_div_done) begin
                    w_cmp_fsm     = 1'b1;
                    w_div_flag_en = 1'b1;
                    w_state_nxt   = RUN;
                end
            end
            ILLC: begin
                w_cmp_fsm   = 1'b1;
                w_cmp_exc   = 1'b1;
                w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    assign w_accept = i_req_valid && w_req_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= RUN;
            r_pv    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pv    <= (r_pv << 1) | PIPE_LAT'(w_issue_pipe);
        end
    end

    // NOTE: tag storage is left unreset; the reset valid bits and FSM state
    // decide when a tag is looked at, so reset logic on the data is waste.
    always_ff @(posedge i_clock) begin
        r_pt[0] <= i_req_tag;
        for (int i = 1; i < PIPE_LAT; i++) r_pt[i] <= r_pt[i-1];
        if (w_accept && !w_issue_pipe) r_held_tag <= i_req_tag;
    end

    assign o_req_ready = w_req_ready;
    assign o_exe_valid = w_issue_pipe;
    assign o_div_start = w_issue_div;
    assign o_exe_rm    = (w_issue_pipe || w_issue_div) ?
                         ((i_req_rm == rm_dyn) ? w_frm : i_req_rm) : 3'b000;
    assign o_exe_tag   = (w_issue_pipe || w_issue_div) ? i_req_tag : '0;

    assign o_cmp_valid = w_pipe_out || w_cmp_fsm;
    assign o_cmp_tag   = w_pipe_out ? r_pt[PIPE_LAT-1] : (w_cmp_fsm ? r_held_tag : '0);
    assign o_cmp_exc   = w_cmp_exc;

    assign o_csr_ready = (r_state == RUN) && w_pipe_empty && !w_accept;
    assign w_csr_acc   = i_csr_valid && o_csr_ready;

    fp_csr u_csr (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_acc      (w_csr_acc),
        .i_addr     (i_csr_addr),
        .i_wen      (i_csr_wen),
        .i_wdata    (i_csr_wdata),
        .i_flag_en  (w_pipe_out || w_div_flag_en),
        .i_flag_set ((w_pipe_out ? i_pipe_flags : 5'b0) | (w_div_flag_en ? i_div_flags : 5'b0)),
        .o_frm      (w_frm),
        .o_fflags   (w_fflags),
        .o_rvalid   (o_csr_rvalid),
        .o_rdata    (o_csr_rdata),
        .o_err      (o_csr_err)
    );

    // fflags is observed through the CSR read port; the tap is kept for debug.
    logic w_unused_fflags;
    assign w_unused_fflags = ^w_fflags;

    assign o_frm = w_frm;

endmodule
